// File: rtl/reset_sequencer_if.sv
// rtl/reset_sequencer_if.sv - button/lock/soft-reset inputs and staged reset outputs of reset_sequencer
// Optional cause_o member is present only when RESET_SEQ_CAUSE_EN is defined.
interface reset_sequencer_if #(
    parameter int NUM_CH = 3
);
    logic              button_i;
    logic              lock_i;
    logic              soft_rst_i;
    logic [NUM_CH-1:0] rst_o;
    logic              ready_o;
`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0]        cause_o;

    modport master (
        output button_i, lock_i, soft_rst_i,
        input  rst_o, ready_o, cause_o
    );
    modport slave (
        input  button_i, lock_i, soft_rst_i,
        output rst_o, ready_o, cause_o
    );
`else
    modport master (
        output button_i, lock_i, soft_rst_i,
        input  rst_o, ready_o
    );
    modport slave (
        input  button_i, lock_i, soft_rst_i,
        output rst_o, ready_o
    );
`endif
endinterface

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - staged reset release gated by debounced button and PLL lock, on USB_CLK60G
// Defining RESET_SEQ_CAUSE_EN adds cause_o (0 rst_i, 1 button, 2 lock loss, 3 soft).
module reset_sequencer #(
    parameter int NUM_CH          = 3,
    parameter int STAGE_CYCLES    = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input logic              clk_i,
    input logic              rst_i,
    reset_sequencer_if.slave bus
);
    localparam int SW = $clog2(STAGE_CYCLES);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [SW-1:0]     STAGE_LAST = SW'(STAGE_CYCLES - 1);
    localparam logic [DW-1:0]     DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_CH-1:0] ALL_HELD   = {NUM_CH{1'b1}};
    localparam logic [NUM_CH-1:0] FIRST_OPEN = ALL_HELD << 1;

    typedef enum logic [1:0] {HOLD, RELEASE, RUN} state_t;

    logic              btn_s1, btn_s2, lock_s1, lock_s2;
    logic              btn_released;
    logic [DW-1:0]     deb_cnt;
    state_t            state;
    logic [SW-1:0]     stage_cnt;
    logic [NUM_CH-1:0] rst_q;
    logic [NUM_CH-1:0] rst_shift;
    logic              ready_q;
    logic              ok;
    logic              abort;

    assign ok        = btn_released & lock_s2;
    assign abort     = ~ok | bus.soft_rst_i;
    assign rst_shift = rst_q << 1;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_s1  <= 1'b0;
            btn_s2  <= 1'b0;
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
        end else begin
            btn_s1  <= bus.button_i;
            btn_s2  <= btn_s1;
            lock_s1 <= bus.lock_i;
            lock_s2 <= lock_s1;
        end
    end

    // Counter only runs while the synchronized button disagrees with the debounced state.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            btn_released <= 1'b0;
            deb_cnt      <= '0;
        end else if (btn_s2 == btn_released) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_LAST) begin
            btn_released <= btn_s2;
            deb_cnt      <= '0;
        end else begin
            deb_cnt <= deb_cnt + SW'(0) + DW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= HOLD;
            stage_cnt <= '0;
            rst_q     <= ALL_HELD;
            ready_q   <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    rst_q   <= ALL_HELD;
                    ready_q <= 1'b0;
                    if (abort) begin
                        stage_cnt <= '0;
                    end else if (stage_cnt == STAGE_LAST) begin
                        stage_cnt <= '0;
                        rst_q     <= FIRST_OPEN;
                        if (FIRST_OPEN == '0) begin
                            state   <= RUN;
                            ready_q <= 1'b1;
                        end else begin
                            state <= RELEASE;
                        end
                    end else begin
                        stage_cnt <= stage_cnt + SW'(1);
                    end
                end
                default: begin
                    if (abort) begin
                        state     <= HOLD;
                        stage_cnt <= '0;
                        rst_q     <= ALL_HELD;
                        ready_q   <= 1'b0;
                    end else if (state == RELEASE) begin
                        // Bits clear bottom-up, so shifting left opens exactly the next channel.
                        if (stage_cnt == STAGE_LAST) begin
                            stage_cnt <= '0;
                            rst_q     <= rst_shift;
                            if (rst_shift == '0) begin
                                state   <= RUN;
                                ready_q <= 1'b1;
                            end
                        end else begin
                            stage_cnt <= stage_cnt + SW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign bus.rst_o   = rst_q;
    assign bus.ready_o = ready_q;

`ifdef RESET_SEQ_CAUSE_EN
    logic [1:0] cause_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cause_q <= 2'd0;
        end else if (state != HOLD && abort) begin
            if (!btn_released)
                cause_q <= 2'd1;
            else if (!lock_s2)
                cause_q <= 2'd2;
            else
                cause_q <= 2'd3;
        end
    end

    assign bus.cause_o = cause_q;
`endif
endmodule
